// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM states and
// the error-counter width helper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } tt_state_e;

  // A full sweep can mismatch on all 2^n vectors, which needs n+1 bits.
  function automatic int tt_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Free-running hold counter: ticks on the last cycle of each HOLD-cycle window
// and restarts from zero; clr parks it at zero.
module hold_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(HOLD);

  logic [W-1:0] count;

  assign tick = (count == W'(HOLD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Exhaustively drives every input vector into a combinational unit, holds each
// for HOLD cycles and compares the unit's output against an expected truth table.
module truth_table_sweep
  import tt_pkg::*;
#(
  parameter int                  N_IN   = 3,
  parameter int                  HOLD   = 4,
  parameter logic [2**N_IN-1:0]  EXP_TT = 8'b1110_1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cont,
  input  logic                        dut_y,
  output logic [N_IN-1:0]             stim,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [tt_width(N_IN)-1:0]   err_cnt,
  output logic                        fail_valid,
  output logic [N_IN-1:0]             first_fail
);

  tt_state_e state;
  logic      mode_cont;
  logic      hold_clr;
  logic      tick;
  logic      mismatch;
  logic      last_vec;

  // The timer only runs in DRIVE, so every entry into DRIVE starts a fresh window.
  assign hold_clr = (state != ST_DRIVE);
  assign mismatch = (dut_y != EXP_TT[stim]);
  assign last_vec = (stim == {N_IN{1'b1}});

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (hold_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      stim       <= '0;
      mode_cont  <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_DRIVE;
            stim       <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            mode_cont  <= cont;
          end
        end

        ST_DRIVE: begin
          if (tick) begin
            if (mismatch) begin
              err_cnt <= err_cnt + 1'b1;
              if (!fail_valid) begin
                first_fail <= stim;
                fail_valid <= 1'b1;
              end
            end
            if (last_vec) begin
              // The final compare is folded in here since err_cnt lags by one edge.
              state <= ST_DONE;
              pass  <= (err_cnt == '0) && !mismatch;
            end else begin
              stim <= stim + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (mode_cont) begin
            state      <= ST_DRIVE;
            stim       <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench for truth_table_sweep: directed and random unit tables,
// continuous mode, mid-sweep reset and start held through a sweep.
module tb_truth_table_sweep;

  localparam int          N_IN   = 3;
  localparam int          HOLD   = 4;
  localparam int          NV     = 2 ** N_IN;
  localparam int          SWEEP  = NV * HOLD;
  localparam logic [7:0]  EXP_TT = 8'hE8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       dut_y;
  logic [2:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic       fail_valid;
  logic [2:0] first_fail;

  // Truth table of the simulated unit under test; dut_y follows stim combinationally.
  logic [7:0] impl_tt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle logs: entry i-1 is sampled after edge k+i, k being the start edge.
  logic [2:0] stim_log[$];
  logic       done_log[$];
  logic       busy_log[$];
  logic [3:0] err_log[$];
  logic       pass_log[$];

  always #5 clk = ~clk;

  assign dut_y = impl_tt[stim];

  truth_table_sweep #(
    .N_IN   (N_IN),
    .HOLD   (HOLD),
    .EXP_TT (EXP_TT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .dut_y      (dut_y),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns just after that edge (k).
  task automatic start_sweep(input logic c);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'(($urandom_range(0, 1)));
  endtask

  // Observe `cycles` edges; with jitter, start/cont toggle randomly and must be ignored.
  task automatic watch(input int cycles, input bit jitter);
    stim_log.delete();
    done_log.delete();
    busy_log.delete();
    err_log.delete();
    pass_log.delete();
    for (int i = 1; i <= cycles; i++) begin
      if (jitter) begin
        start = 1'(($urandom_range(0, 1)));
        cont  = 1'(($urandom_range(0, 1)));
      end
      @(negedge clk);
      stim_log.push_back(stim);
      done_log.push_back(done);
      busy_log.push_back(busy);
      err_log.push_back(err_cnt);
      pass_log.push_back(pass);
    end
    if (jitter) begin
      start = 1'b0;
      cont  = 1'b0;
    end
  endtask

  function automatic int done_count();
    int n = 0;
    foreach (done_log[i]) if (done_log[i]) n++;
    return n;
  endfunction

  // Stepping model: after edge k+i the vector on stim is i/HOLD, saturating at NV-1.
  function automatic int stim_errors(input int from_i, input int to_i, input int base);
    int n = 0;
    for (int i = from_i; i <= to_i; i++) begin
      int e = (i - base) / HOLD;
      if (e > NV - 1) e = NV - 1;
      if (stim_log[i-1] !== 3'(e)) n++;
    end
    return n;
  endfunction

  // Reference result of one sweep, straight from comparing the two tables.
  function automatic void model(input logic [7:0] tt, output int errs, output int ff);
    errs = 0;
    ff   = -1;
    for (int v = 0; v < NV; v++) begin
      if (tt[v] != EXP_TT[v]) begin
        errs++;
        if (ff < 0) ff = v;
      end
    end
  endfunction

  task automatic run_single(input string tag, input logic [7:0] tt);
    int errs, ff;
    impl_tt = tt;
    model(tt, errs, ff);
    start_sweep(1'b0);
    watch(SWEEP, 1'b1);
    check({tag, ".done_count"}, done_count(), 1);
    check({tag, ".done_at_k+32"}, done_log[SWEEP-1], 1);
    check({tag, ".stim_trace"}, stim_errors(1, SWEEP, 0), 0);
    check({tag, ".err_cnt"}, err_cnt, errs);
    check({tag, ".fail_valid"}, fail_valid, (errs != 0));
    if (errs != 0) check({tag, ".first_fail"}, first_fail, ff);
    check({tag, ".pass"}, pass, (errs == 0));
    check({tag, ".busy_in_done"}, busy, 1);
    @(negedge clk);
    check({tag, ".done_ends"}, done, 0);
    check({tag, ".idle_after"}, busy, 0);
    check({tag, ".pass_kept"}, pass, (errs == 0));
  endtask

  initial begin
    int errs, ff;
    logic [7:0] tt;

    rst     = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    impl_tt = EXP_TT;
    repeat (2) @(negedge clk);
    check("reset.stim", stim, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.pass", pass, 0);
    check("reset.err_cnt", err_cnt, 0);
    check("reset.fail_valid", fail_valid, 0);
    check("reset.first_fail", first_fail, 0);
    rst = 1'b0;
    @(negedge clk);

    run_single("majority", 8'hE8);
    run_single("fault_at_5", 8'hC8);
    run_single("tied_0", 8'h00);
    run_single("tied_1", 8'hFF);
    for (int r = 0; r < 6; r++) begin
      run_single($sformatf("random%0d", r), 8'($urandom));
    end

    // Continuous mode: back-to-back sweeps with one DONE cycle between them.
    tt = 8'($urandom);
    impl_tt = tt;
    model(tt, errs, ff);
    start_sweep(1'b1);
    watch(100, 1'b1);
    check("cont.done_count", done_count(), 3);
    check("cont.done_k+32", done_log[31], 1);
    check("cont.done_k+65", done_log[64], 1);
    check("cont.done_k+98", done_log[97], 1);
    check("cont.busy_low_cycles", busy_log.sum() with (int'(!item)), 0);
    check("cont.stim_restart1", stim_log[32], 0);
    check("cont.stim_restart2", stim_log[65], 0);
    check("cont.stim_trace2", stim_errors(34, 65, 33), 0);
    check("cont.err_cleared", err_log[32], 0);
    check("cont.pass_kept", pass_log[32], (errs == 0));
    check("cont.err_final", err_log[97], errs);
    check("cont.pass_final", pass_log[97], (errs == 0));
    rst = 1'b1;
    #1;
    check("cont.reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Leave a nonzero first_fail behind, then reset part-way through a sweep.
    run_single("pre_abort", 8'h68);
    impl_tt = 8'h00;
    start_sweep(1'b0);
    watch(12, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort.stim", stim, 0);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.pass", pass, 0);
    check("abort.err_cnt", err_cnt, 0);
    check("abort.fail_valid", fail_valid, 0);
    check("abort.first_fail", first_fail, 0);
    @(negedge clk);
    rst = 1'b0;
    watch(40, 1'b0);
    check("abort.no_done", done_count(), 0);
    check("abort.stays_idle", busy, 0);
    run_single("after_abort", 8'hE8);

    // Start held high: the second sweep begins only after a pass through IDLE.
    impl_tt = 8'hE8;
    @(negedge clk);
    start = 1'b1;
    cont  = 1'b0;
    @(negedge clk);
    watch(66, 1'b0);
    start = 1'b0;
    check("held.done_count", done_count(), 2);
    check("held.done_k+32", done_log[31], 1);
    check("held.done_k+66", done_log[65], 1);
    check("held.idle_k+33", busy_log[32], 0);
    check("held.busy_k+34", busy_log[33], 1);
    check("held.stim_k+37", stim_log[36], 0);
    check("held.stim_k+38", stim_log[37], 1);
    check("held.pass", pass, 1);
    repeat (3) @(negedge clk);
    check("held.final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter N_IN, default 3, gives the number of stimulus inputs to the combinational unit under test; the legal range is 1..8.
REQ-002 Parameter HOLD, default 4, gives the clock cycles each input vector is held; the legal range is 2..255.
REQ-003 Parameter EXP_TT, default 8'b1110_1000, is a 2^N_IN-bit expected truth table; bit v is the expected output for input vector v.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
REQ-005 The remaining ports SHALL be:
- start  in  1  begin a sweep; level sampled
- cont  in  1  continuous mode; sampled with start
- dut_y  in  1  output of the unit under test
- stim  out  N_IN  input vector driven to the unit under test
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at the end of each sweep
- pass  out  1  previous sweep had zero mismatches
- err_cnt  out  N_IN+1  mismatches in the current or previous sweep
- fail_valid  out  1  first_fail holds a captured vector
- first_fail  out  N_IN  first mismatching vector of the sweep

Function
REQ-006 The FSM SHALL have three states: IDLE, DRIVE and DONE. The state encoding is free.
REQ-007 In IDLE, start=1 at a clock edge SHALL cause:
- transition to DRIVE;
- stim<=0 and hold_cnt<=0;
- err_cnt<=0, fail_valid<=0, pass<=0;
- cont latched into mode_cont.
REQ-008 In DRIVE, hold_cnt SHALL increment every cycle. At the edge where hold_cnt==HOLD-1, dut_y SHALL be compared with EXP_TT[stim] and hold_cnt SHALL clear.
REQ-009 On a mismatch, err_cnt SHALL increment. If fail_valid==0, first_fail<=stim and fail_valid<=1. Later mismatches SHALL NOT alter first_fail.
REQ-010 After a compare with stim<2^N_IN-1, stim SHALL increment by 1. After a compare with stim==2^N_IN-1, the FSM SHALL go to DONE and stim SHALL hold its value.
REQ-011 Vector v SHALL be compared at edge k+(v+1)*HOLD, where k is the start edge. The FSM enters DONE at edge k+2^N_IN*HOLD.
REQ-012 In DONE, for exactly one cycle:
- done=1;
- pass=1 if and only if the final err_cnt==0, with the last compare included.
REQ-013 On leaving DONE:
- if mode_cont==0, the FSM SHALL go to IDLE;
- if mode_cont==1, the FSM SHALL go to DRIVE with stim=0, err_cnt=0 and fail_valid=0; pass keeps its last value.
REQ-014 busy SHALL be 1 in DRIVE and DONE and 0 in IDLE.
REQ-015 start SHALL be ignored while busy=1; the cont input SHALL be ignored outside the start edge.
REQ-016 err_cnt needs no saturation, because it is N_IN+1 bits wide and the maximum count is 2^N_IN.
REQ-017 The stim, pass, err_cnt, first_fail and fail_valid outputs SHALL be registered; done and busy SHALL decode directly from state.

Reset
REQ-018 rst=1 SHALL force, asynchronously and regardless of the clock:
- state=IDLE, stim=0, hold_cnt=0, mode_cont=0;
- err_cnt=0, first_fail=0, fail_valid=0, pass=0.
REQ-019 Reset asserted mid-sweep SHALL abort the sweep with no done pulse. The first edge after reset releases SHALL be treated as IDLE.

Structure
REQ-020 A shared package tt_pkg SHALL hold:
- state constants: ST_IDLE, ST_DRIVE, ST_DONE;
- function tt_width(n), returning n+1.
REQ-021 The hold counter SHALL be a separate sub-module hold_timer with:
- parameter HOLD;
- inputs clk, rst, clr;
- output tick, asserted when the count reaches HOLD-1.
REQ-022 The total RTL size SHALL be about 150-250 lines.

Verification
REQ-023 Correct unit: N_IN=3, HOLD=4, EXP_TT=8'hE8, dut_y=majority(stim), start pulsed at edge k -> stim steps 0..7 every 4 cycles; done=1 at k+32; pass=1; err_cnt=0; fail_valid=0.
REQ-024 Faulty unit: dut_y=majority(stim) XOR (stim==5) -> err_cnt=1; first_fail=5; fail_valid=1; pass=0.
REQ-025 Multiple faults: dut_y tied to 0 -> err_cnt=4; first_fail=3; pass=0.
REQ-026 Continuous mode: start=1 with cont=1 -> done pulses at k+32, k+65 and k+98; stim returns to 0 after each DONE; busy stays 1 throughout.
REQ-027 Reset mid-sweep: rst pulsed at k+13 -> all outputs 0 immediately, no done pulse; a new start gives a normal 32-cycle sweep.
REQ-028 Start while busy: start=1 held for the whole sweep with cont=0 -> start is ignored during DRIVE; after DONE the block re-enters DRIVE only through IDLE, so the next sweep's vector 0 is compared at k+34+HOLD.
